// File: rtl/attn_pkg.sv
// rtl/attn_pkg.sv - shared attention datapath constants and row-major index helper
package attn_pkg;

   localparam int DEF_DATA_WIDTH = 4;
   localparam int DEF_ROW_IN     = 4;
   localparam int DEF_COL_IN     = 8;

   // Flattened position of element (r,c) in a row-major matrix with cols columns.
   function automatic int elem_idx(input int r, input int c, input int cols);
      return r * cols + c;
   endfunction

endpackage

// File: rtl/matrix_bank.sv
// rtl/matrix_bank.sv - ROW_IN x COL_IN storage with a row write port and flattened matrix read
module matrix_bank
   import attn_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int ROW_IN     = DEF_ROW_IN,
   parameter  int COL_IN     = DEF_COL_IN,
   localparam int ROW_W      = $clog2(ROW_IN),
   localparam int ROW_BITS   = DATA_WIDTH * COL_IN,
   localparam int MAT_BITS   = ROW_BITS * ROW_IN
) (
   input  logic                clk,
   input  logic                we,
   input  logic [ROW_W-1:0]    wr_row,
   input  logic [ROW_BITS-1:0] wr_data,
   output logic [MAT_BITS-1:0] rd_mat
);

   logic [ROW_BITS-1:0] mem [ROW_IN];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_row] <= wr_data;
      end
   end

   for (genvar r = 0; r < ROW_IN; r++) begin : g_row
      assign rd_mat[DATA_WIDTH*elem_idx(r, 0, COL_IN) +: ROW_BITS] = mem[r];
   end

endmodule

// File: rtl/matrix_row_buffer.sv
// rtl/matrix_row_buffer.sv - ping-pong row collector presenting whole matrices to the transpose stage
module matrix_row_buffer
   import attn_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int ROW_IN     = DEF_ROW_IN,
   parameter  int COL_IN     = DEF_COL_IN,
   localparam int ROW_BITS   = DATA_WIDTH * COL_IN,
   localparam int MAT_BITS   = ROW_BITS * ROW_IN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ROW_BITS-1:0] in_row,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [MAT_BITS-1:0] out_mat
);

   localparam int               ROW_W    = $clog2(ROW_IN);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROW_IN - 1);

   logic [1:0]          full;
   logic [1:0]          full_nxt;
   logic                wr_bank;
   logic                rd_bank;
   logic [ROW_W-1:0]    row_cnt;
   logic                in_beat;
   logic                out_beat;
   logic                row_last;
   logic [MAT_BITS-1:0] mat0;
   logic [MAT_BITS-1:0] mat1;

   assign in_ready  = !rst && !full[wr_bank];
   assign out_valid = full[rd_bank];
   assign in_beat   = in_valid && in_ready;
   assign out_beat  = out_valid && out_ready;
   assign row_last  = (row_cnt == LAST_ROW);

   // Fill and drain always target different banks, so both edits can land together.
   always_comb begin
      full_nxt = full;
      if (in_beat && row_last) begin
         full_nxt[wr_bank] = 1'b1;
      end
      if (out_beat) begin
         full_nxt[rd_bank] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full    <= 2'b00;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         row_cnt <= '0;
      end else begin
         full <= full_nxt;
         if (in_beat) begin
            row_cnt <= row_last ? '0 : row_cnt + 1'b1;
            if (row_last) begin
               wr_bank <= !wr_bank;
            end
         end
         if (out_beat) begin
            rd_bank <= !rd_bank;
         end
      end
   end

   matrix_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_IN     (ROW_IN),
      .COL_IN     (COL_IN)
   ) u_bank0 (
      .clk     (clk),
      .we      (in_beat && !wr_bank),
      .wr_row  (row_cnt),
      .wr_data (in_row),
      .rd_mat  (mat0)
   );

   matrix_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_IN     (ROW_IN),
      .COL_IN     (COL_IN)
   ) u_bank1 (
      .clk     (clk),
      .we      (in_beat && wr_bank),
      .wr_row  (row_cnt),
      .wr_data (in_row),
      .rd_mat  (mat1)
   );

   // Gate to zero so the transpose stage never sees a stale or half-filled bank.
   assign out_mat = out_valid ? (rd_bank ? mat1 : mat0) : '0;

endmodule
